// File: rtl/commit_controller.sv
// Retirement sequencer for the ROB head: regfile writeback, committed stores over a
// request/ack D-mem handshake, mispredict squash/redirect and the sticky halt state.
module commit_controller #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 head_valid,
    input  logic                 head_ready,
    input  logic                 head_wr_mem,
    input  logic                 head_mispredict,
    input  logic                 head_halt,
    input  logic [REG_IDX_W-1:0] head_dest_reg,
    input  logic [XLEN-1:0]      head_result,
    input  logic [XLEN-1:0]      head_target_pc,
    input  logic [XLEN-1:0]      head_addr,
    input  logic [XLEN-1:0]      head_store_data,
    output logic                 mem_req_valid,
    output logic [XLEN-1:0]      mem_req_addr,
    output logic [XLEN-1:0]      mem_req_data,
    input  logic                 mem_req_ready,
    input  logic                 mem_ack,
    output logic                 retire_valid,
    output logic                 rf_wr_en,
    output logic [REG_IDX_W-1:0] rf_wr_idx,
    output logic [XLEN-1:0]      rf_wr_data,
    output logic                 squash,
    output logic [XLEN-1:0]      squash_pc,
    output logic                 halted,
    output logic [CNT_W-1:0]     retired_count
);

    typedef enum logic [1:0] {RUN, ST_REQ, ST_WAIT, HALTED} state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] store_addr, store_data;
    logic            latch_store;
    logic            head_fire;

    assign head_fire     = head_valid & head_ready;
    assign mem_req_addr  = store_addr;
    assign mem_req_data  = store_data;

    // Mealy outputs; everything is forced low while reset is held so the ROB
    // and D-mem see no strobes even though the head inputs may be live.
    always_comb begin
        state_next    = state;
        latch_store   = 1'b0;
        mem_req_valid = 1'b0;
        retire_valid  = 1'b0;
        rf_wr_en      = 1'b0;
        rf_wr_idx     = '0;
        rf_wr_data    = '0;
        squash        = 1'b0;
        squash_pc     = '0;
        halted        = 1'b0;
        if (reset) begin
            case (state)
                RUN: begin
                    if (head_fire) begin
                        if (head_wr_mem) begin
                            latch_store = 1'b1;
                            state_next  = ST_REQ;
                        end else begin
                            retire_valid = 1'b1;
                            rf_wr_en     = |head_dest_reg;
                            rf_wr_idx    = head_dest_reg;
                            rf_wr_data   = head_result;
                            if (head_mispredict) begin
                                squash    = 1'b1;
                                squash_pc = head_target_pc;
                            end
                            if (head_halt) state_next = HALTED;
                        end
                    end
                end
                ST_REQ: begin
                    mem_req_valid = 1'b1;
                    // An ack that arrives without ready belongs to no request and is dropped.
                    if (mem_req_ready) begin
                        if (mem_ack) begin
                            retire_valid = 1'b1;
                            state_next   = RUN;
                        end else begin
                            state_next   = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        retire_valid = 1'b1;
                        state_next   = RUN;
                    end
                end
                HALTED: begin
                    halted = 1'b1;
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            retired_count <= '0;
            store_addr    <= '0;
            store_data    <= '0;
        end else begin
            state <= state_next;
            if (retire_valid) retired_count <= retired_count + CNT_W'(1);
            if (latch_store) begin
                store_addr <= head_addr;
                store_data <= head_store_data;
            end
        end
    end

endmodule

// File: tb/tb_commit_controller.sv
// Directed bench for commit_controller: stimulus pushes expected retires and store
// requests into queues that a negedge monitor pops and compares.
module tb_commit_controller;

    logic        clock;
    logic        reset;
    logic        head_valid, head_ready, head_wr_mem, head_mispredict, head_halt;
    logic [4:0]  head_dest_reg;
    logic [31:0] head_result, head_target_pc, head_addr, head_store_data;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr, mem_req_data;
    logic        mem_req_ready, mem_ack;
    logic        retire_valid, rf_wr_en;
    logic [4:0]  rf_wr_idx;
    logic [31:0] rf_wr_data;
    logic        squash;
    logic [31:0] squash_pc;
    logic        halted;
    logic [31:0] retired_count;

    commit_controller #(.XLEN(32), .REG_IDX_W(5), .CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .head_valid(head_valid), .head_ready(head_ready), .head_wr_mem(head_wr_mem),
        .head_mispredict(head_mispredict), .head_halt(head_halt),
        .head_dest_reg(head_dest_reg), .head_result(head_result),
        .head_target_pc(head_target_pc), .head_addr(head_addr),
        .head_store_data(head_store_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready), .mem_ack(mem_ack),
        .retire_valid(retire_valid), .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx),
        .rf_wr_data(rf_wr_data), .squash(squash), .squash_pc(squash_pc),
        .halted(halted), .retired_count(retired_count)
    );

    typedef struct {
        logic        en;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        sq;
        logic [31:0] pc;
    } ret_t;

    ret_t        ret_q[$];
    logic [63:0] mem_q[$];
    int          vectors  = 0;
    int          failures = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ret(input logic en, input logic [4:0] idx, input logic [31:0] data,
                            input logic sq, input logic [31:0] pc);
        ret_t r;
        r.en = en; r.idx = idx; r.data = data; r.sq = sq; r.pc = pc;
        ret_q.push_back(r);
    endtask

    // Monitor: every retire and every accepted store request must match the queue head.
    initial begin
        ret_t        r;
        logic [63:0] m;
        forever begin
            @(negedge clock);
            if (retire_valid) begin
                if (ret_q.size() == 0) begin
                    check("unexpected_retire", 64'd1, 64'd0);
                end else begin
                    r = ret_q.pop_front();
                    check("ret_rf_wr_en", 64'(rf_wr_en), 64'(r.en));
                    if (r.en) begin
                        check("ret_rf_wr_idx", 64'(rf_wr_idx), 64'(r.idx));
                        check("ret_rf_wr_data", 64'(rf_wr_data), 64'(r.data));
                    end
                    check("ret_squash", 64'(squash), 64'(r.sq));
                    if (r.sq) check("ret_squash_pc", 64'(squash_pc), 64'(r.pc));
                end
            end else if (squash) begin
                check("squash_without_retire", 64'(squash), 64'd0);
            end
            if (mem_req_valid && mem_req_ready) begin
                if (mem_q.size() == 0) begin
                    check("unexpected_mem_req", 64'd1, 64'd0);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_req_addr_data", {mem_req_addr, mem_req_data}, m);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        head_valid = 0; head_ready = 0; head_wr_mem = 0; head_mispredict = 0; head_halt = 0;
        head_dest_reg = 0; head_result = 0; head_target_pc = 0; head_addr = 0; head_store_data = 0;
    endtask

    task automatic alu(input logic [4:0] dest, input logic [31:0] res, input logic mis,
                       input logic hlt, input logic [31:0] tpc);
        idle();
        head_valid = 1; head_ready = 1; head_dest_reg = dest; head_result = res;
        head_mispredict = mis; head_halt = hlt; head_target_pc = tpc;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        idle();
        head_valid = 1; head_ready = 1; head_wr_mem = 1; head_addr = addr; head_store_data = data;
        // Mispredict/halt flags on a store must be ignored.
        head_mispredict = 1; head_halt = 1; head_target_pc = 32'hBAD0;
    endtask

    initial begin
        reset = 0; mem_req_ready = 0; mem_ack = 0;
        // Live head during reset must not leak through the combinational outputs.
        alu(5'd7, 32'h1111, 1'b1, 1'b0, 32'h80);
        #3;
        check("rst_retire_valid", 64'(retire_valid), 64'd0);
        check("rst_rf_wr_en", 64'(rf_wr_en), 64'd0);
        check("rst_squash", 64'(squash), 64'd0);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_retired_count", 64'(retired_count), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        cyc();
        idle();
        reset = 1;

        // ALU head with a destination register
        alu(5'd1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        push_ret(1'b1, 5'd1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        @(negedge clock);
        cyc();
        check("alu_count", 64'(retired_count), 64'd1);

        // x0 destination: retires without regfile write
        alu(5'd0, 32'h1234, 1'b0, 1'b0, 32'h0);
        push_ret(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        @(negedge clock);
        cyc();
        check("x0_count", 64'(retired_count), 64'd2);

        // Store with slow ready, then ack two cycles after acceptance
        store(32'h100, 32'hAA);
        @(negedge clock);
        check("st_run_retire", 64'(retire_valid), 64'd0);
        check("st_run_reqv", 64'(mem_req_valid), 64'd0);
        cyc();
        idle();
        head_addr = 32'hFFFF_FFFF;
        mem_q.push_back({32'h100, 32'hAA});
        for (int i = 0; i < 3; i++) begin
            mem_req_ready = 0;
            mem_ack = (i == 1);
            @(negedge clock);
            check("st_req_wait_reqv", 64'(mem_req_valid), 64'd1);
            check("st_req_addr_data", {mem_req_addr, mem_req_data}, {32'h100, 32'hAA});
            cyc();
        end
        mem_ack = 0; mem_req_ready = 1;
        @(negedge clock);
        check("st_req_accept_reqv", 64'(mem_req_valid), 64'd1);
        cyc();
        mem_req_ready = 0;
        @(negedge clock);
        check("st_wait_reqv", 64'(mem_req_valid), 64'd0);
        cyc();
        mem_ack = 1;
        push_ret(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        @(negedge clock);
        check("st_ack_retire", 64'(retire_valid), 64'd1);
        cyc();
        mem_ack = 0;
        check("st_count", 64'(retired_count), 64'd3);

        // Store accepted and acked in one cycle, then an ALU head retires at once
        store(32'h200, 32'h55);
        cyc();
        idle();
        mem_req_ready = 1; mem_ack = 1;
        mem_q.push_back({32'h200, 32'h55});
        push_ret(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        @(negedge clock);
        cyc();
        mem_req_ready = 0; mem_ack = 0;
        alu(5'd3, 32'h77, 1'b0, 1'b0, 32'h0);
        push_ret(1'b1, 5'd3, 32'h77, 1'b0, 32'h0);
        @(negedge clock);
        check("fast_next_retire", 64'(retire_valid), 64'd1);
        cyc();
        idle();
        check("fast_count", 64'(retired_count), 64'd5);

        // Mispredicted branch
        alu(5'd2, 32'h9, 1'b1, 1'b0, 32'h0000_0040);
        push_ret(1'b1, 5'd2, 32'h9, 1'b1, 32'h40);
        @(negedge clock);
        check("mis_squash", 64'(squash), 64'd1);
        cyc();
        idle();
        @(negedge clock);
        check("mis_squash_drop", 64'(squash), 64'd0);
        cyc();
        check("mis_count", 64'(retired_count), 64'd6);

        // Halt, then a live head must not retire
        alu(5'd0, 32'h0, 1'b0, 1'b1, 32'h0);
        push_ret(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        @(negedge clock);
        cyc();
        alu(5'd4, 32'h5, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) store(32'h44, 32'h44);
            @(negedge clock);
            check("halt_halted", 64'(halted), 64'd1);
            check("halt_no_retire", 64'(retire_valid), 64'd0);
            check("halt_no_req", 64'(mem_req_valid), 64'd0);
            cyc();
        end
        check("halt_count", 64'(retired_count), 64'd7);

        // Reset leaves HALTED; then reset mid-store abandons it
        idle();
        reset = 0;
        #1;
        check("halt_rst_halted", 64'(halted), 64'd0);
        check("halt_rst_count", 64'(retired_count), 64'd0);
        cyc();
        reset = 1;
        alu(5'd6, 32'h1, 1'b0, 1'b0, 32'h0);
        push_ret(1'b1, 5'd6, 32'h1, 1'b0, 32'h0);
        @(negedge clock);
        cyc();
        store(32'h300, 32'h66);
        cyc();
        idle();
        mem_req_ready = 1;
        mem_q.push_back({32'h300, 32'h66});
        @(negedge clock);
        check("rst_st_reqv", 64'(mem_req_valid), 64'd1);
        cyc();
        mem_req_ready = 0;
        check("rst_st_pre_count", 64'(retired_count), 64'd1);
        #2;
        reset = 0;
        mem_ack = 1;
        #1;
        check("rst_st_reqv_low", 64'(mem_req_valid), 64'd0);
        check("rst_st_addr", 64'(mem_req_addr), 64'd0);
        check("rst_st_count", 64'(retired_count), 64'd0);
        check("rst_st_no_retire", 64'(retire_valid), 64'd0);
        cyc();
        mem_ack = 0;
        reset = 1;
        @(negedge clock);
        check("rst_st_idle_retire", 64'(retire_valid), 64'd0);
        cyc();
        alu(5'd8, 32'hABC, 1'b0, 1'b0, 32'h0);
        push_ret(1'b1, 5'd8, 32'hABC, 1'b0, 32'h0);
        @(negedge clock);
        check("rst_st_run_retire", 64'(retire_valid), 64'd1);
        cyc();
        idle();
        check("rst_st_final_count", 64'(retired_count), 64'd1);

        @(negedge clock);
        check("ret_queue_drained", 64'(ret_q.size()), 64'd0);
        check("mem_queue_drained", 64'(mem_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule

// File: doc/commit_controller.md
Name: commit_controller

Overview:
- Sequences retirement at the ROB head for the O3 core.
- Each cycle it decides whether the head entry retires, which covers:
  - register-file writeback;
  - a two-phase request/ack handshake that performs a committed store to the data memory port;
  - squash plus redirect PC on a mispredicted branch;
  - entering the halted state.
- Sits between the ROB head and the regfile / D-mem write port. It replaces ad-hoc retire logic in commit_stage.

Parameters:
XLEN, 32, datapath / address width
REG_IDX_W, 5, architectural register index width
CNT_W, 32, retired-instruction counter width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
head_valid  input  1  ROB head entry is valid
head_ready  input  1  head entry has completed execution
head_wr_mem  input  1  head entry is a store
head_mispredict  input  1  head entry is a mispredicted branch
head_halt  input  1  head entry is a halt/wfi
head_dest_reg  input  REG_IDX_W  architectural destination register
head_result  input  XLEN  writeback value
head_target_pc  input  XLEN  correct PC for a mispredicted branch
head_addr  input  XLEN  store address
head_store_data  input  XLEN  store data
mem_req_valid  output  1  store request to D-mem
mem_req_addr  output  XLEN  latched store address
mem_req_data  output  XLEN  latched store data
mem_req_ready  input  1  D-mem accepts the request this cycle
mem_ack  input  1  D-mem write completed
retire_valid  output  1  head retires this cycle; ROB pops at the next edge
rf_wr_en  output  1  regfile write enable
rf_wr_idx  output  REG_IDX_W  regfile write index
rf_wr_data  output  XLEN  regfile write data
squash  output  1  flush the pipeline, redirect fetch
squash_pc  output  XLEN  redirect target
halted  output  1  core halted, sticky
retired_count  output  CNT_W  number of retired instructions

Behaviour:
- States: RUN, ST_REQ, ST_WAIT, HALTED.
- Reset (reset=0, asynchronous): state=RUN, retired_count=0, store address/data regs=0. All outputs are 0 while in reset, including mem_req_valid. Reset asserted during ST_REQ/ST_WAIT abandons the store, with no retire.
- retire_valid, rf_*, squash and squash_pc are combinational from state and head inputs (Mealy). Retirement therefore has 0-cycle latency in RUN.
- RUN, when head_valid & head_ready:
  - head_wr_mem=0: retire_valid=1 this cycle. rf_wr_en=1 iff head_dest_reg!=0, with rf_wr_idx=head_dest_reg and rf_wr_data=head_result.
    - If head_mispredict is also set: squash=1 and squash_pc=head_target_pc in the same cycle.
    - If head_halt is also set: go to HALTED.
  - head_wr_mem=1: no retire this cycle. Latch head_addr/head_store_data and go to ST_REQ. head_mispredict and head_halt are ignored for stores.
- RUN, when head_valid=0 or head_ready=0: idle, all strobes 0.
- ST_REQ: mem_req_valid=1, with mem_req_addr/data taken from the latches.
  - mem_req_ready=1 and mem_ack=0: go to ST_WAIT.
  - mem_req_ready=1 and mem_ack=1 in the same cycle: retire_valid=1 with rf_wr_en=0, then go to RUN.
  - mem_ack without mem_req_ready: ignored.
- ST_WAIT: mem_req_valid=0. On mem_ack: retire_valid=1 with rf_wr_en=0, then go to RUN. Otherwise wait indefinitely, with no timeout.
- While in ST_REQ/ST_WAIT, the ROB must hold the head stable. Head inputs are not sampled in these states, and a head_valid drop does not cancel the store.
- HALTED: absorbing until reset. All strobes 0, halted=1, mem_req_valid=0.
- retired_count increments by 1 on each clock edge where retire_valid=1, and wraps modulo 2^CNT_W.
- At most one retirement per cycle. squash is asserted only together with retire_valid.

Test Plan:
- Reset then ALU head (valid, ready, dest=5'd1, result=32'hDEAD_BEEF) -> same cycle: retire_valid=1, rf_wr_en=1, rf_wr_idx=1, rf_wr_data=DEADBEEF; retired_count=1 after the edge.
- Head with dest_reg=0, result=32'h1234 -> retire_valid=1, rf_wr_en=0.
- Store with addr=32'h100, data=32'hAA, mem_req_ready held low 3 cycles, then ready=1, then ack 2 cycles later:
  - mem_req_valid high for 4 cycles with addr=100 and data=AA;
  - retire_valid pulses exactly once, in the ack cycle;
  - no rf write.
- Store where mem_req_ready and mem_ack arrive in the same cycle -> retire in that cycle, state back to RUN the next cycle, and the next ALU head retires immediately.
- Mispredict head with target_pc=32'h0000_0040 -> retire_valid=1, squash=1, squash_pc=40 for one cycle.
- Halt head retires, then head_valid/ready are held high -> halted=1, no further retire_valid, retired_count frozen. Asserting reset low mid-store (ST_WAIT) -> mem_req_valid=0 immediately, retired_count=0, state RUN.
